// File: rtl/striVe_uart_pkg.sv
// Shared types and constants for the striVe UART receiver.
// Holds the receive FSM state encoding and the frame geometry.
package striVe_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_rx_state_t;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_MIN_DIV   = 2;
    localparam int UART_IDX_W     = $clog2(UART_DATA_BITS);

    // Even parity: the data bits plus the parity bit must XOR to zero.
    function automatic logic even_parity_bad(input logic [UART_DATA_BITS-1:0] data,
                                             input logic par_bit);
        return ^{data, par_bit};
    endfunction

endpackage

// File: rtl/striVe_uart_rx_fifo.sv
// Synchronous receive FIFO with count register and wrap-around pointers.
// A push on a full FIFO is dropped unless a pop happens in the same cycle.
module striVe_uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             overflow_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign pop_ok     = pop_i & ~empty_o;
    assign push_ok    = push_i & (~full_o | pop_i);
    assign overflow_o = push_i & full_o & ~pop_i;
    assign data_o     = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // On full with simultaneous pop, wr_ptr equals rd_ptr: the head leaves as the new byte lands.
            if (push_ok) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/strive_uart_rx.sv
// striVe UART receiver: synchronizer, bit-period down-counter, frame FSM, receive FIFO.
// Define STRIVE_UART_RX_PARITY_EN for 8E1 frames with a live parity_err; default is 8N1.
module strive_uart_rx
    import striVe_uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ser_rx,
    input  logic [DIV_WIDTH-1:0] cfg_divider,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [7:0]           rd_data,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overflow
);
    logic                      rx_meta_q;
    logic                      rx_s_q;
    logic                      rx_prev_q;
    uart_rx_state_t            state_q;
    logic [DIV_WIDTH-1:0]      cnt_q;
    logic [UART_IDX_W-1:0]     bit_idx_q;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic                      frame_err_q;
    logic                      overflow_q;
    logic [DIV_WIDTH-1:0]      div_eff;
    logic                      tick;
    logic                      par_bad;
    logic                      push;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      fifo_ovf;

`ifdef STRIVE_UART_RX_PARITY_EN
    logic par_bad_q;
    logic parity_err_q;
    assign par_bad    = par_bad_q;
    assign parity_err = parity_err_q;
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    assign div_eff = (cfg_divider < DIV_WIDTH'(UART_MIN_DIV)) ? DIV_WIDTH'(UART_MIN_DIV) : cfg_divider;
    assign tick    = (cnt_q == '0);
    assign push    = (state_q == STOP) & tick & rx_s_q & ~par_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= ser_rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
`ifdef STRIVE_UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            frame_err_q <= 1'b0;
            overflow_q  <= fifo_ovf;
`ifdef STRIVE_UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (!rx_s_q && rx_prev_q) begin
                        cnt_q   <= (div_eff >> 1) - DIV_WIDTH'(1);
                        state_q <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        if (rx_s_q) begin
                            state_q <= IDLE;
                        end else begin
                            cnt_q     <= div_eff - DIV_WIDTH'(1);
                            bit_idx_q <= '0;
                            state_q   <= DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q - DIV_WIDTH'(1);
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_q[bit_idx_q] <= rx_s_q;
                        cnt_q              <= div_eff - DIV_WIDTH'(1);
                        if (bit_idx_q == UART_IDX_W'(UART_DATA_BITS - 1)) begin
`ifdef STRIVE_UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + UART_IDX_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q - DIV_WIDTH'(1);
                    end
                end
`ifdef STRIVE_UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        par_bad_q <= even_parity_bad(shift_q, rx_s_q);
                        cnt_q     <= div_eff - DIV_WIDTH'(1);
                        state_q   <= STOP;
                    end else begin
                        cnt_q <= cnt_q - DIV_WIDTH'(1);
                    end
                end
`endif
                STOP: begin
                    // Returning to IDLE at mid-stop lets an immediately following start edge be caught.
                    if (tick) begin
                        if (!rx_s_q) frame_err_q <= 1'b1;
`ifdef STRIVE_UART_RX_PARITY_EN
                        else if (par_bad_q) parity_err_q <= 1'b1;
                        par_bad_q <= 1'b0;
`endif
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - DIV_WIDTH'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    striVe_uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .data_i     (shift_q),
        .pop_i      (rd_ready),
        .data_o     (rd_data),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .overflow_o (fifo_ovf)
    );

    assign rd_valid  = ~fifo_empty;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_strive_uart_rx.sv
// Directed bench for strive_uart_rx: serial frames in, scoreboard of expected bytes and pulse counts.
// Parity cases run only when STRIVE_UART_RX_PARITY_EN is defined.
module tb_strive_uart_rx;
`ifdef STRIVE_UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ser_rx = 1'b1;
    logic [31:0] cfg_divider = 32'd8;
    logic        rd_ready = 1'b0;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        frame_err;
    logic        parity_err;
    logic        overflow;

    int errors = 0;
    int checks = 0;
    int fe_n = 0, pe_n = 0, ov_n = 0;
    int fe_b, pe_b, ov_b;
    int occ;
    logic [7:0] recv_q[$];
    logic [7:0] exp_q[$];

    strive_uart_rx #(.FIFO_DEPTH(DEPTH), .DIV_WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .ser_rx      (ser_rx),
        .cfg_divider (cfg_divider),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .frame_err   (frame_err),
        .parity_err  (parity_err),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (rd_valid && rd_ready) recv_q.push_back(rd_data);
            if (frame_err) fe_n++;
            if (parity_err) pe_n++;
            if (overflow) ov_n++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bit_time(input logic v, input int n);
        ser_rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int n, input logic bad_par);
        bit_time(1'b0, n);
        for (int i = 0; i < 8; i++) bit_time(b[i], n);
        if (PAR) bit_time((^b) ^ bad_par, n);
        bit_time(stop, n);
        ser_rx = 1'b1;
    endtask

    // Good frame: scoreboard knows whether the FIFO will hold it or drop it.
    task automatic send_good(input logic [7:0] b, input int n);
        if (rd_ready) exp_q.push_back(b);
        else if (occ < DEPTH) begin
            exp_q.push_back(b);
            occ++;
        end
        send_frame(b, 1'b1, n, 1'b0);
    endtask

    task automatic mark();
        fe_b = fe_n;
        pe_b = pe_n;
        ov_b = ov_n;
    endtask

    task automatic check_pulses(input string tag, input int efe, input int epe, input int eov);
        chk({tag, " frame_err pulses"}, fe_n - fe_b, efe);
        chk({tag, " parity_err pulses"}, pe_n - pe_b, epe);
        chk({tag, " overflow pulses"}, ov_n - ov_b, eov);
    endtask

    task automatic check_bytes(input string tag);
        logic [31:0] o;
        chk({tag, " byte count"}, recv_q.size(), exp_q.size());
        while (exp_q.size() > 0) begin
            o = (recv_q.size() > 0) ? {24'h0, recv_q.pop_front()} : 32'hxxxxxxxx;
            chk({tag, " rd_data"}, o, {24'h0, exp_q.pop_front()});
        end
        recv_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " rd_valid"}, rd_valid, 1'b0);
        chk({tag, " rd_data"}, rd_data, 8'h00);
        chk({tag, " frame_err"}, frame_err, 1'b0);
        chk({tag, " parity_err"}, parity_err, 1'b0);
        chk({tag, " overflow"}, overflow, 1'b0);
    endtask

    initial begin
        occ = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // basic back-to-back receive
        cfg_divider = 32'd8;
        rd_ready = 1'b1;
        mark();
        send_good(8'h55, 8);
        send_good(8'hA3, 8);
        bit_time(1'b1, 6);
        check_bytes("basic");
        check_pulses("basic", 0, 0, 0);

        // framing error then good frame
        mark();
        send_frame(8'h3C, 1'b0, 8, 1'b0);
        bit_time(1'b1, 16);
        check_bytes("frame_err");
        check_pulses("frame_err", 1, 0, 0);
        mark();
        send_good(8'h3C, 8);
        bit_time(1'b1, 6);
        check_bytes("after frame_err");
        check_pulses("after frame_err", 0, 0, 0);

        // false start
        cfg_divider = 32'd16;
        mark();
        bit_time(1'b0, 4);
        bit_time(1'b1, 60);
        check_bytes("false start");
        check_pulses("false start", 0, 0, 0);

        // divider below minimum runs as 2
        cfg_divider = 32'd1;
        mark();
        send_good(8'hC6, 2);
        bit_time(1'b1, 8);
        check_bytes("min div");
        check_pulses("min div", 0, 0, 0);

        // overflow on the fifth byte
        cfg_divider = 32'd8;
        rd_ready = 1'b0;
        occ = 0;
        mark();
        for (int i = 1; i <= 5; i++) send_good(i[7:0], 8);
        bit_time(1'b1, 6);
        chk("overflow rd_valid", rd_valid, 1'b1);
        chk("overflow head", rd_data, 8'h01);
        check_pulses("overflow", 0, 0, 1);
        rd_ready = 1'b1;
        bit_time(1'b1, 10);
        check_bytes("overflow drain");
        occ = 0;

        // reset mid-frame with a byte waiting in the FIFO
        rd_ready = 1'b0;
        send_frame(8'h5A, 1'b1, 8, 1'b0);
        bit_time(1'b1, 6);
        chk("pre-reset head", rd_data, 8'h5A);
        bit_time(1'b0, 8);
        bit_time(1'b1, 24);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid-frame reset");
        bit_time(1'b1, 3);
        rst = 1'b0;
        bit_time(1'b1, 100);
        chk("post-reset rd_valid", rd_valid, 1'b0);
        rd_ready = 1'b1;
        recv_q.delete();
        mark();
        send_good(8'h7E, 8);
        bit_time(1'b1, 6);
        check_bytes("post-reset");
        check_pulses("post-reset", 0, 0, 0);

`ifdef STRIVE_UART_RX_PARITY_EN
        mark();
        send_frame(8'h07, 1'b1, 8, 1'b1);
        bit_time(1'b1, 10);
        check_bytes("parity bad");
        check_pulses("parity bad", 0, 1, 0);
        mark();
        send_good(8'h07, 8);
        bit_time(1'b1, 6);
        check_bytes("parity good");
        check_pulses("parity good", 0, 0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
